// File: rtl/csr_unit.sv
// csr_unit -- machine-mode CSR file and trap sequencer for the single-cycle core.
//
// Executes CSRRW/CSRRS/CSRRC (register and immediate forms) and returns the old
// CSR value to the writeback mux. It synchronizes the UART and timer interrupt
// lines, and redirects the PC on trap entry and on an accepted mret.
//
// Optional feature macro: CSR_MCYCLE_EN adds a 64-bit mcycle counter at
// 0xB00 (low) / 0xB80 (high). Without it those addresses read 0 and ignore writes.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   instr_valid           instruction retires this cycle (0 = stall)
//   csr_wre, csr_rde      CSR write / read enables from the decoder
//   is_mret               current instruction is mret
//   funct3                CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//   csr_addr              CSR address (instr[31:20])
//   rs1_data, zimm        operand for register / immediate forms
//   pc                    PC of the current instruction
//   ext_irq, timer_irq    asynchronous level interrupt lines
//   csr_rdata             old value of the addressed CSR (0 when csr_rde=0)
//   trap_taken            interrupt accepted; the core squashes this instruction
//   redirect, redirect_pc PC redirect request and target
module csr_unit #(
    parameter logic [31:0] RESET_MTVEC     = 32'h0000_0100,
    parameter int          IRQ_SYNC_STAGES = 2      // legal range 2..3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic        csr_wre,
    input  logic        csr_rde,
    input  logic        is_mret,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic [31:0] pc,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [31:0] csr_rdata,
    output logic        trap_taken,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;
`ifdef CSR_MCYCLE_EN
    localparam logic [11:0] A_MCYCLE  = 12'hB00;
    localparam logic [11:0] A_MCYCLEH = 12'hB80;
`endif

    localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

    // ---------------- state ----------------
    logic        mst_mie_q,  mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic        meie_q,     meie_d;
    logic        mtie_q,     mtie_d;
    // mtvec/mepc keep all 32 bits; the low two bits are masked on every read.
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;

    logic [IRQ_SYNC_STAGES-1:0] ext_sync_q;
    logic [IRQ_SYNC_STAGES-1:0] tmr_sync_q;

    logic meip, mtip;
    assign meip = ext_sync_q[IRQ_SYNC_STAGES-1];
    assign mtip = tmr_sync_q[IRQ_SYNC_STAGES-1];

    // ---------------- read path ----------------
    logic [31:0] old_val, src, new_val;

`ifdef CSR_MCYCLE_EN
    logic [63:0] mcycle_q, mcycle_d;
`endif

    always_comb begin
        old_val = '0;
        case (csr_addr)
            A_MSTATUS: old_val = {24'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
            A_MIE:     old_val = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
            A_MIP:     old_val = {20'b0, meip, 3'b0, mtip, 7'b0};
            A_MTVEC:   old_val = {mtvec_q[31:2], 2'b00};
            A_MEPC:    old_val = {mepc_q[31:2], 2'b00};
            A_MCAUSE:  old_val = mcause_q;
`ifdef CSR_MCYCLE_EN
            A_MCYCLE:  old_val = mcycle_q[31:0];
            A_MCYCLEH: old_val = mcycle_q[63:32];
`endif
            default:   old_val = '0;
        endcase
    end

    assign csr_rdata = csr_rde ? old_val : 32'h0;

    assign src = funct3[2] ? {27'b0, zimm} : rs1_data;

    always_comb begin
        case (funct3[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = old_val | src;
            2'b11:   new_val = old_val & ~src;
            default: new_val = old_val;
        endcase
    end

    // ---------------- trap / mret decision ----------------
    logic pend_ext, pend_tmr, mret_acc, wr_en;

    assign pend_ext   = meip & meie_q;
    assign pend_tmr   = mtip & mtie_q;
    assign trap_taken = instr_valid & mst_mie_q & (pend_ext | pend_tmr);
    assign mret_acc   = is_mret & instr_valid & ~trap_taken;
    assign wr_en      = csr_wre & instr_valid & ~trap_taken;

    assign redirect    = trap_taken | mret_acc;
    assign redirect_pc = mret_acc ? {mepc_q[31:2], 2'b00} : {mtvec_q[31:2], 2'b00};

    // ---------------- next state ----------------
    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        meie_d     = meie_q;
        mtie_d     = mtie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;

        if (wr_en) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mst_mie_d  = new_val[3];
                    mst_mpie_d = new_val[7];
                end
                A_MIE: begin
                    meie_d = new_val[11];
                    mtie_d = new_val[7];
                end
                A_MTVEC:  mtvec_d  = new_val;
                A_MEPC:   mepc_d   = new_val;
                A_MCAUSE: mcause_d = new_val;
                default: ;
            endcase
        end

        // Trap beats mret; either overrides the mstatus bits of a same-cycle write
        // (a trap already suppresses the write entirely).
        if (trap_taken) begin
            mepc_d     = pc;
            mcause_d   = pend_ext ? CAUSE_EXT : CAUSE_TMR;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (mret_acc) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end
    end

`ifdef CSR_MCYCLE_EN
    // A write to one half replaces it and suppresses that cycle's increment,
    // so no carry reaches the other half.
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (wr_en && csr_addr == A_MCYCLE)  mcycle_d = {mcycle_q[63:32], new_val};
        if (wr_en && csr_addr == A_MCYCLEH) mcycle_d = {new_val, mcycle_q[31:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcycle_q <= '0;
        else        mcycle_q <= mcycle_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            meie_q     <= 1'b0;
            mtie_q     <= 1'b0;
            mtvec_q    <= RESET_MTVEC;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            meie_q     <= meie_d;
            mtie_q     <= mtie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    // Plain flop chains; the last stage is the architectural MEIP/MTIP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync_q <= '0;
            tmr_sync_q <= '0;
        end else begin
            ext_sync_q <= {ext_sync_q[IRQ_SYNC_STAGES-2:0], ext_irq};
            tmr_sync_q <= {tmr_sync_q[IRQ_SYNC_STAGES-2:0], timer_irq};
        end
    end

endmodule
